// File: rtl/rv_decode_stage_if.sv
// Handshake and decoded-bundle signals between fetch, the decode stage and execute.
// The stage itself connects through the slave modport; the upstream/downstream side uses master.
interface rv_decode_stage_if #(
    parameter int unsigned XLEN = 32
) ();
    localparam int unsigned ILEN = 32;
    localparam int unsigned RW   = 5;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [ILEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [RW-1:0]   out_rd;
    logic [RW-1:0]   out_rs1;
    logic [RW-1:0]   out_rs2;
    logic [XLEN-1:0] out_imm;
    logic            out_imm_sel;
    logic [2:0]      out_fmt;
    logic            out_rd_we;
    logic            out_illegal;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_imm, out_imm_sel, out_fmt,
               out_rd_we, out_illegal
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_imm, out_imm_sel, out_fmt,
               out_rd_we, out_illegal
    );
endinterface

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: combinational format/legality decode of in_instr feeding a
// one-entry output register with valid/ready back-pressure and flush.
module rv_decode_stage #(
    parameter int unsigned XLEN      = 32,
    parameter bit          SUPPORT_M = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    rv_decode_stage_if.slave    bus
);
    localparam int unsigned ILEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [RW-1:0]   rd;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [XLEN-1:0] imm;
        logic            imm_sel;
        logic [2:0]      fmt;
        logic            rd_we;
        logic            illegal;
    } dec_bundle_t;

    logic [ILEN-1:0] instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RW-1:0]   rd_f;
    logic [RW-1:0]   rs1_f;
    logic [RW-1:0]   rs2_f;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    logic            r_legal;
    logic [2:0]      fmt;
    logic            legal;
    dec_bundle_t     dec;

    logic            valid_q;
    dec_bundle_t     bundle_q;
    logic            in_ready_c;
    logic            load_c;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd_f   = instr[11:7];
    assign rs1_f  = instr[19:15];
    assign rs2_f  = instr[24:20];

    // Every immediate is sign-extended from instr[31] by widening a signed value.
    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    assign r_legal = (funct7 == F7_BASE)
                  || ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
                  || (SUPPORT_M && (funct7 == F7_MUL));

    // Opcode to format, plus per-opcode funct3/funct7 legality.
    always_comb begin : fmt_decode
        fmt   = FMT_ILL;
        legal = 1'b0;
        case (opcode)
            OP_OP: begin
                fmt   = FMT_R;
                legal = r_legal;
            end
            OP_IMM: begin
                fmt   = FMT_I;
                legal = !((funct3 == 3'b001) && (funct7 != F7_BASE))
                     && !((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
            end
            OP_LOAD: begin
                fmt   = FMT_I;
                legal = !((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));
            end
            OP_JALR: begin
                fmt   = FMT_I;
                legal = (funct3 == 3'b000);
            end
            OP_STORE: begin
                fmt   = FMT_S;
                legal = (funct3 < 3'b011);
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                legal = !((funct3 == 3'b010) || (funct3 == 3'b011));
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                legal = 1'b1;
            end
            OP_JAL: begin
                fmt   = FMT_J;
                legal = 1'b1;
            end
            default: begin
                fmt   = FMT_ILL;
                legal = 1'b0;
            end
        endcase
        if (instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end
    end

    // Fields absent from a format stay zero; an illegal word keeps only pc and opcode.
    always_comb begin : bundle_build
        dec        = '0;
        dec.pc     = bus.in_pc;
        dec.opcode = opcode;
        if (!legal) begin
            dec.fmt     = FMT_ILL;
            dec.illegal = 1'b1;
        end else begin
            dec.fmt = fmt;
            case (fmt)
                FMT_R: begin
                    dec.rd     = rd_f;
                    dec.rs1    = rs1_f;
                    dec.rs2    = rs2_f;
                    dec.funct3 = funct3;
                    dec.funct7 = funct7;
                end
                FMT_I: begin
                    dec.rd      = rd_f;
                    dec.rs1     = rs1_f;
                    dec.funct3  = funct3;
                    dec.imm     = imm_i;
                    dec.imm_sel = 1'b1;
                end
                FMT_S: begin
                    dec.rs1     = rs1_f;
                    dec.rs2     = rs2_f;
                    dec.funct3  = funct3;
                    dec.imm     = imm_s;
                    dec.imm_sel = 1'b1;
                end
                FMT_B: begin
                    dec.rs1    = rs1_f;
                    dec.rs2    = rs2_f;
                    dec.funct3 = funct3;
                    dec.imm    = imm_b;
                end
                FMT_U: begin
                    dec.rd      = rd_f;
                    dec.imm     = imm_u;
                    dec.imm_sel = 1'b1;
                end
                FMT_J: begin
                    dec.rd      = rd_f;
                    dec.imm     = imm_j;
                    dec.imm_sel = 1'b1;
                end
                default: begin
                    dec.fmt = FMT_ILL;
                end
            endcase
            // rd is already zero for formats without a destination.
            dec.rd_we = (dec.rd != '0);
        end
    end

    assign in_ready_c = !bus.flush && (!valid_q || bus.out_ready);
    assign load_c     = bus.in_valid && in_ready_c;

    // One-entry output register; flush beats load, load beats consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (bus.flush) begin
            valid_q  <= 1'b0;
        end else if (load_c) begin
            valid_q  <= 1'b1;
            bundle_q <= dec;
        end else if (bus.out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = valid_q;
    assign bus.out_pc      = bundle_q.pc;
    assign bus.out_opcode  = bundle_q.opcode;
    assign bus.out_funct3  = bundle_q.funct3;
    assign bus.out_funct7  = bundle_q.funct7;
    assign bus.out_rd      = bundle_q.rd;
    assign bus.out_rs1     = bundle_q.rs1;
    assign bus.out_rs2     = bundle_q.rs2;
    assign bus.out_imm     = bundle_q.imm;
    assign bus.out_imm_sel = bundle_q.imm_sel;
    assign bus.out_fmt     = bundle_q.fmt;
    assign bus.out_rd_we   = bundle_q.rd_we;
    assign bus.out_illegal = bundle_q.illegal;

endmodule

// File: doc/rv_decode_stage.md
# rv_decode_stage

Registered, parametrised RV32I instruction decode stage. It sits between instruction fetch and the register file/execute stage. It accepts one instruction per cycle over a valid/ready handshake and decodes all six base formats (R/I/S/B/U/J). It produces sign-extended immediates of width XLEN, a register-write enable and an illegal-instruction flag. Results are held in a one-entry output register that supports back-pressure and flush.

## Interface
Parameters:
- XLEN, 32 — datapath width; immediate and PC width; must be ≥ 32
- SUPPORT_M, 0 — 1: R-type funct7 = 7'b0000001 (M extension) is legal

Ports:
- clk  input  1  — clock; all state updates on rising edge
- rst_n  input  1  — reset, asynchronous, active-low
- flush  input  1  — discard the held instruction and the current input
- in_valid  input  1  — in_instr/in_pc valid
- in_ready  output  1  — stage can accept input this cycle
- in_instr  input  32  — raw instruction word
- in_pc  input  XLEN  — PC of in_instr
- out_valid  output  1  — decoded bundle valid
- out_ready  input  1  — downstream accepts bundle
- out_pc  output  XLEN  — registered in_pc
- out_opcode  output  7  — instr[6:0]
- out_funct3  output  3  — instr[14:12]; 0 for U/J
- out_funct7  output  7  — instr[31:25] for R-type, else 0
- out_rd, out_rs1, out_rs2  output  5 each — register selects; 0 when the format lacks the field
- out_imm  output  XLEN  — sign-extended immediate; 0 for R-type
- out_imm_sel  output  1  — 1 when operand B is the immediate (every format except R and B)
- out_fmt  output  3  — 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal
- out_rd_we  output  1  — instruction writes rd, and rd ≠ 0
- out_illegal  output  1  — illegal encoding

## Operation
**Opcode map**
- 0110011 → R.
- 0010011, 0000011, 1100111 → I.
- 0100011 → S.
- 1100011 → B.
- 0110111, 0010111 → U.
- 1101111 → J.

**Immediates**
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- All immediates are sign-extended from bit 31 of the instruction to XLEN.

**Field presence**
- rd: R, I, U, J.
- rs1: R, I, S, B.
- rs2: R, S, B.

**out_rd_we**
- 1 for R, I, U and J with rd ≠ 0.
- Always 0 when illegal.

**Illegal conditions** (out_fmt = 7; all select and immediate fields 0; out_opcode still registered)
- instr[1:0] ≠ 11, or the opcode is not in the map.
- R-type funct7 is not one of:
  - 0000000;
  - 0100000 with funct3 ∈ {000, 101};
  - 0000001 when SUPPORT_M = 1.
- OP-IMM shift with a bad funct7:
  - funct3 = 001 requires funct7 = 0000000;
  - funct3 = 101 requires funct7 ∈ {0000000, 0100000}.
- Branch funct3 ∈ {010, 011}.
- Load funct3 ∈ {011, 110, 111}.
- Store funct3 ≥ 011.
- JALR funct3 ≠ 000.
- An illegal instruction is still delivered (out_valid = 1) so the downstream stage can trap.

**Handshake**
- in_ready = !flush && (!out_valid || out_ready).
- Load: in_valid && in_ready → register loads the decoded bundle; out_valid = 1 next cycle.
- Consume: out_valid && out_ready with no new load → out_valid = 0 next cycle.
- While out_valid && !out_ready, all out_* hold stable.
- Flush has priority over load and consume: next cycle out_valid = 0; in_instr is not captured.

## Timing
- Latency 1 cycle from an accepted input to out_valid.
- Throughput 1 instruction/cycle while out_ready = 1.
- Decode is combinational on in_instr; all outputs are register outputs.
- in_ready is combinational from out_valid, out_ready and flush.
- Reset (rst_n low, asynchronous) sets every registered output to 0:
  - out_valid 0;
  - out_fmt 0.
- Reset asserted mid-transfer drops the held instruction.
- After rst_n deasserts, in_ready = 1 on the first cycle.
- Simultaneous consume and load: the register reloads, out_valid stays 1, no bubble.
- in_valid = 0 with out_ready = 1: a bubble; out_valid falls; data fields may hold old values.

## Test plan
- Type-I: in_instr = 0xFFF10093 (addi x1,x2,-1) → after 1 cycle, required bundle:
  - out_fmt 1, rd 1, rs1 2, rs2 0;
  - imm 0xFFFFFFFF, imm_sel 1, rd_we 1.
- Store/branch formats:
  - 0x00532423 (sw x5,8(x6)) → fmt 2, rs1 6, rs2 5, imm 8, rd 0, rd_we 0;
  - 0xFE000EE3 (beq x0,x0,-4) → fmt 3, imm 0xFFFFFFFC, imm_sel 0.
- Jump/upper formats:
  - 0x001000EF (jal x1,2048) → fmt 5, imm 0x800, rd 1, rd_we 1;
  - 0x123452B7 (lui x5) → fmt 4, imm 0x12345000.
- Illegal encodings, each → out_valid 1, out_illegal 1, fmt 7, rd_we 0:
  - 0x00000000;
  - 0x40002033 (funct7 0100000, funct3 010);
  - 0x02000033 with SUPPORT_M = 0 (same word is legal with SUPPORT_M = 1).
- Back-pressure: stream 3 instructions with out_ready low for 4 cycles mid-stream → outputs frozen, in_ready 0; no instruction lost or duplicated; order preserved.
- Flush/reset:
  - flush pulse while out_valid = 1 and in_valid = 1 → next cycle out_valid 0, input not captured;
  - rst_n pulled low mid-stream, asynchronously → all outputs 0 immediately;
  - after release, in_ready 1.
